mem_pingpong: RTL and testbench

- Multi-lane, double-buffered (ping-pong) tile memory that feeds the systolic array.
- A loader fills one bank while the array reads the other. Bank ownership is handed over by commit/release handshakes.
- Each lane carries one systolic row of operands. All lanes share one address.
- Generalises the single-lane dual-port RAM with: lane count, per-lane write masks, selectable read latency, and bank-full tracking.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_sdp.sv | 34 +++
 rtl/mem_pingpong.sv | 117 +++++++++++
 tb/tb_mem_pingpong.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the ping-pong tile memory.
package mem_pkg;

  typedef logic bank_t;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  // LSB position of a lane's element inside a packed multi-lane word.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mem_sdp.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module mem_sdp
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Output register only loads on a read, so it holds between reads.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_pingpong.sv
// Multi-lane double-buffered tile memory with commit/release bank handover.
module mem_pingpong
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [LANES-1:0]       wr_lane_mask,
  input  logic [LANES*WIDTH-1:0] wr_data,
  input  logic                   wr_commit,
  output logic                   wr_ready,
  output logic                   wr_drop,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic                   rd_release,
  output logic                   rd_avail,
  output logic [LANES*WIDTH-1:0] rd_data,
  output logic                   rd_valid,
  output logic [1:0]             full_cnt
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("mem_pingpong: RD_LAT must be 1 or 2");
  end

  logic [1:0]             r_full;
  bank_t                  r_wb;
  bank_t                  r_rb;
  logic                   r_drop;
  logic                   r_v1;
  logic                   w_wr_fire;
  logic                   w_commit;
  logic                   w_release;
  logic                   w_rd_issue;
  logic [LANES*WIDTH-1:0] w_ram_q;

  assign wr_ready = ~r_full[r_wb];
  assign rd_avail = r_full[r_rb];
  assign full_cnt = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign wr_drop  = r_drop;

  assign w_wr_fire  = wr_en & wr_ready & ~rst;
  assign w_commit   = wr_commit & wr_ready;
  assign w_release  = rd_release & rd_avail;
  assign w_rd_issue = rd_en & rd_avail & ~rst;

  // Commit and release always target different banks, so both bit updates can coexist.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= '0;
      r_wb   <= '0;
      r_rb   <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= (wr_en | wr_commit) & ~wr_ready;
      if (w_commit) begin
        r_full[r_wb] <= 1'b1;
        r_wb         <= ~r_wb;
      end
      if (w_release) begin
        r_full[r_rb] <= 1'b0;
        r_rb         <= ~r_rb;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mem_sdp #(
      .WIDTH     (WIDTH),
      .DEPTH     (2 * DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH + 1)
    ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .i_we   (w_wr_fire & wr_lane_mask[k]),
      .i_waddr({r_wb, wr_addr}),
      .i_wdata(wr_data[lane_lsb(k, WIDTH) +: WIDTH]),
      .i_re   (w_rd_issue),
      .i_raddr({r_rb, rd_addr}),
      .o_rdata(w_ram_q[lane_lsb(k, WIDTH) +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_v1 <= 1'b0;
    else     r_v1 <= w_rd_issue;
  end

  if (RD_LAT == 1) begin : g_lat1
    assign rd_valid = r_v1;
    assign rd_data  = w_ram_q;
  end else begin : g_lat2
    logic                   r_v2;
    logic [LANES*WIDTH-1:0] r_d2;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v2 <= 1'b0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_d2 <= w_ram_q;
      end
    end

    assign rd_valid = r_v2;
    assign rd_data  = r_d2;
  end

endmodule

// File: tb/tb_mem_pingpong.sv
// Directed table-driven bench; RD_LAT=1 and RD_LAT=2 instances share stimulus.
module tb_mem_pingpong;

  localparam int unsigned W  = 8;
  localparam int unsigned L  = 4;
  localparam int unsigned D  = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst, wr_en, wr_commit, rd_en, rd_release;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [L-1:0]  wr_lane_mask;
  logic [31:0]   wr_data;

  logic        ready1, drop1, avail1, v1, ready2, drop2, avail2, v2;
  logic [31:0] d1, d2;
  logic [1:0]  cnt1, cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_pingpong #(.WIDTH(W), .LANES(L), .DEPTH(D), .ADDR_WIDTH(AW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_mask(wr_lane_mask),
    .wr_data(wr_data), .wr_commit(wr_commit), .wr_ready(ready1), .wr_drop(drop1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release), .rd_avail(avail1),
    .rd_data(d1), .rd_valid(v1), .full_cnt(cnt1));

  mem_pingpong #(.WIDTH(W), .LANES(L), .DEPTH(D), .ADDR_WIDTH(AW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane_mask(wr_lane_mask),
    .wr_data(wr_data), .wr_commit(wr_commit), .wr_ready(ready2), .wr_drop(drop2),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_release(rd_release), .rd_avail(avail2),
    .rd_data(d2), .rd_valid(v2), .full_cnt(cnt2));

  typedef struct {
    logic        rst, wr_en;
    logic [3:0]  wa, mask;
    logic [31:0] wd;
    logic        commit, rd_en;
    logic [3:0]  ra;
    logic        rel;
    logic        e_ready, e_drop, e_avail;
    logic [1:0]  e_cnt;
    logic        e_v1;
    logic [31:0] e_d1;
    logic        e_v2;
    logic [31:0] e_d2;
  } vec_t;

  vec_t tv_a[3];
  vec_t tv_b[14];

  function automatic vec_t mk(input logic r, we, input logic [3:0] wa, mask, input logic [31:0] wd,
                              input logic cm, re, input logic [3:0] ra, input logic rel,
                              input logic er, edr, eav, input logic [1:0] ecnt,
                              input logic ev1, input logic [31:0] ed1,
                              input logic ev2, input logic [31:0] ed2);
    vec_t v;
    v.rst = r; v.wr_en = we; v.wa = wa; v.mask = mask; v.wd = wd; v.commit = cm;
    v.rd_en = re; v.ra = ra; v.rel = rel; v.e_ready = er; v.e_drop = edr; v.e_avail = eav;
    v.e_cnt = ecnt; v.e_v1 = ev1; v.e_d1 = ed1; v.e_v2 = ev2; v.e_d2 = ed2;
    return v;
  endfunction

  // Lane k of address a holds base + 4*a + k.
  function automatic logic [31:0] fill_word(input int unsigned a, input int unsigned base);
    logic [31:0] w;
    for (int unsigned k = 0; k < L; k++) w[k*8 +: 8] = 8'(base + 4 * a + k);
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; wr_en = v.wr_en; wr_addr = v.wa; wr_lane_mask = v.mask; wr_data = v.wd;
    wr_commit = v.commit; rd_en = v.rd_en; rd_addr = v.ra; rd_release = v.rel;
    @(posedge clk);
    #1;
    chk({tag, " wr_ready1"}, 32'(ready1), 32'(v.e_ready));
    chk({tag, " wr_ready2"}, 32'(ready2), 32'(v.e_ready));
    chk({tag, " wr_drop1"},  32'(drop1),  32'(v.e_drop));
    chk({tag, " wr_drop2"},  32'(drop2),  32'(v.e_drop));
    chk({tag, " rd_avail1"}, 32'(avail1), 32'(v.e_avail));
    chk({tag, " rd_avail2"}, 32'(avail2), 32'(v.e_avail));
    chk({tag, " full_cnt1"}, 32'(cnt1),   32'(v.e_cnt));
    chk({tag, " full_cnt2"}, 32'(cnt2),   32'(v.e_cnt));
    chk({tag, " lat1 rd_valid"}, 32'(v1), 32'(v.e_v1));
    chk({tag, " lat1 rd_data"},  d1,      v.e_d1);
    chk({tag, " lat2 rd_valid"}, 32'(v2), 32'(v.e_v2));
    chk({tag, " lat2 rd_data"},  d2,      v.e_d2);
  endtask

  localparam logic [31:0] D5  = 32'h17161514;
  localparam logic [31:0] D2  = 32'h0B0A0908;
  localparam logic [31:0] B13 = 32'h4F4E4D4C;
  localparam logic [31:0] B15 = 32'h7F7E7D7C;
  localparam logic [31:0] MSK = 32'h03AA01AA;
  localparam logic [31:0] ONE = 32'hFFFFFFFF;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_lane_mask = '0; wr_data = '0;
    wr_commit = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;

    // Bank0 reads at addr 5 (lat1 then lat2 visibility and hold).
    tv_a[0] = mk(0,0,0,0,0, 0,1,5,0, 1,0,1,1, 1,D5, 0,0);
    tv_a[1] = mk(0,0,0,0,0, 0,0,0,0, 1,0,1,1, 0,D5, 1,D5);
    tv_a[2] = mk(0,0,0,0,0, 0,0,0,0, 1,0,1,1, 0,D5, 0,D5);

    tv_b[0]  = mk(0,1,3,4'hF,32'hDEADBEEF, 0,0,0,0, 0,1,1,2, 0,D5, 0,D5);
    tv_b[1]  = mk(0,0,0,0,0, 1,0,0,0,           0,1,1,2, 0,D5, 0,D5);
    tv_b[2]  = mk(0,0,0,0,0, 0,0,0,0,           0,0,1,2, 0,D5, 0,D5);
    tv_b[3]  = mk(0,0,0,0,0, 0,1,2,1,           1,0,1,1, 1,D2, 0,D5);
    tv_b[4]  = mk(0,1,2,4'hF,ONE, 0,0,0,0,      1,0,1,1, 0,D2, 1,D2);
    tv_b[5]  = mk(0,0,0,0,0, 0,1,3,0,           1,0,1,1, 1,B13, 0,D2);
    tv_b[6]  = mk(0,0,0,0,0, 0,1,15,0,          1,0,1,1, 1,B15, 1,B13);
    tv_b[7]  = mk(0,0,0,0,0, 0,0,0,0,           1,0,1,1, 0,B15, 1,B15);
    tv_b[8]  = mk(0,1,0,4'b0101,32'hAAAAAAAA, 0,0,0,0, 1,0,1,1, 0,B15, 0,B15);
    tv_b[9]  = mk(0,0,0,0,0, 1,0,0,1,           1,0,1,1, 0,B15, 0,B15);
    tv_b[10] = mk(0,0,0,0,0, 0,1,0,0,           1,0,1,1, 1,MSK, 0,B15);
    tv_b[11] = mk(0,0,0,0,0, 0,1,2,0,           1,0,1,1, 1,ONE, 1,MSK);
    tv_b[12] = mk(1,1,1,4'hF,ONE, 0,1,1,0,      1,0,0,0, 0,0, 0,0);
    tv_b[13] = mk(0,0,0,0,0, 0,1,0,0,           1,0,0,0, 0,0, 0,0);

    apply(mk(1,0,0,0,0, 0,0,0,0, 1,0,0,0, 0,0, 0,0), "reset0");
    apply(mk(1,0,0,0,0, 0,0,0,0, 1,0,0,0, 0,0, 0,0), "reset1");

    for (int unsigned a = 0; a < D; a++)
      apply(mk(0,1,4'(a),4'hF,fill_word(a, 0), 0,0,0,0, 1,0,0,0, 0,0, 0,0),
            $sformatf("fill0_a%0d", a));
    apply(mk(0,0,0,0,0, 1,0,0,0, 1,0,1,1, 0,0, 0,0), "commit0");

    for (int i = 0; i < 3; i++) apply(tv_a[i], $sformatf("tvA%0d", i));

    // Last bank1 write shares its cycle with the commit.
    for (int unsigned a = 0; a < D; a++) begin
      if (a == D - 1)
        apply(mk(0,1,4'(a),4'hF,fill_word(a, 8'h40), 1,0,0,0, 0,0,1,2, 0,D5, 0,D5), "fill1_commit");
      else
        apply(mk(0,1,4'(a),4'hF,fill_word(a, 8'h40), 0,0,0,0, 1,0,1,1, 0,D5, 0,D5),
              $sformatf("fill1_a%0d", a));
    end

    for (int i = 0; i < 14; i++) apply(tv_b[i], $sformatf("tvB%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
